// File: rtl/mem_access_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared definitions for the MEM pipeline stage:
//   - memop field layout (REGENABLE bit, access kind codes)
//   - load operation codes
//   - MEM stage FSM state encoding
//   - alignment helper used when MEM_ALIGN_CHECK_EN is defined
// ---------------------------------------------------------------------------
package mem_access_stage_pkg;

    // Bit of memop that requests a register write-back
    localparam int REGENABLE = 2;

    // memop[1:0] access kinds
    localparam logic [1:0] MEMOP_NONE  = 2'b00;
    localparam logic [1:0] MEMOP_LOAD  = 2'b01;
    localparam logic [1:0] MEMOP_STORE = 2'b10;
    localparam logic [1:0] MEMOP_RSVD  = 2'b11;  // behaves like MEMOP_NONE

    // Load extraction operations
    localparam logic [2:0] LOADOP_NOP = 3'd0;
    localparam logic [2:0] LOADOP_LB  = 3'd1;
    localparam logic [2:0] LOADOP_LBU = 3'd2;
    localparam logic [2:0] LOADOP_LH  = 3'd3;
    localparam logic [2:0] LOADOP_LHU = 3'd4;
    localparam logic [2:0] LOADOP_LW  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // Halfword accesses need an even byte offset, word accesses need offset 0.
    // Stores carry no load op, so their width is inferred from the byte
    // enables: two lanes = halfword, four lanes = word.
    function automatic logic is_misaligned(
        input logic       is_load,
        input logic [2:0] loadop,
        input logic [3:0] sel,
        input logic [1:0] low_addr
    );
        logic half_acc;
        logic word_acc;
        if (is_load) begin
            half_acc = (loadop == LOADOP_LH) || (loadop == LOADOP_LHU);
            word_acc = (loadop == LOADOP_LW);
        end else begin
            half_acc = ($countones(sel) == 2);
            word_acc = (sel == 4'b1111);
        end
        return (half_acc && low_addr[0]) || (word_acc && (low_addr != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_stage_load_extender.sv
// ---------------------------------------------------------------------------
// load_extender
// Purely combinational load-data formatter. Selects the addressed byte or
// halfword of a little-endian RAM word and sign/zero-extends it.
// Ports:
//   rdata    in  DATA_W  raw RAM read word
//   low_addr in  2       byte offset within the word
//   loadop   in  3       load operation code (LB/LBU/LH/LHU/LW, else 0)
//   data     out DATA_W  extended load result
// ---------------------------------------------------------------------------
module load_extender
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        low_addr,
    input  logic [2:0]        loadop,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  lanes  [4];
    logic [15:0] halves [2];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = rdata[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign halves[gi] = rdata[16*gi +: 16];
        end
    endgenerate

    assign sel_byte = lanes[low_addr];
    assign sel_half = halves[low_addr[1]];

    always_comb begin
        data = '0;
        case (loadop)
            LOADOP_LB:  data = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
            LOADOP_LBU: data = {{(DATA_W-8){1'b0}}, sel_byte};
            LOADOP_LH:  data = {{(DATA_W-16){sel_half[15]}}, sel_half};
            LOADOP_LHU: data = {{(DATA_W-16){1'b0}}, sel_half};
            LOADOP_LW:  data = rdata;
            default:    data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// MEM pipeline stage. Non-memory ops pass the ALU result to the MEM/WB
// register in one cycle. Loads/stores issue a request/acknowledge RAM
// access, stall the upstream pipeline until the ack (or a timeout abort),
// and for loads register the extended read data as the write-back value.
//
// Parameters:
//   TIMEOUT_CYCLES  WAIT cycles before abort (0 = never abort)
//   DATA_W          data word width
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   mem_memop/exresult/storeData/ramAddr/ramLowAddr/ramSel/loadop/regDest
//                                       EX/MEM register contents
//   ram_req/we/addr/sel/wdata           registered RAM request (outputs)
//   ram_rdata, ram_ack                  RAM response (inputs)
//   stall_req                           freeze EX/MEM and earlier stages
//   wb_regWriteEnable/regDest/data      registered MEM/WB bundle
//   mem_err                             one-cycle pulse on abort
// Optional feature macro:
//   MEM_ALIGN_CHECK_EN  reject misaligned halfword/word accesses with mem_err
// ---------------------------------------------------------------------------
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DATA_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        mem_memop,
    input  logic [DATA_W-1:0] mem_exresult,
    input  logic [DATA_W-1:0] mem_storeData,
    input  logic [29:0]       mem_ramAddr,
    input  logic [1:0]        mem_ramLowAddr,
    input  logic [3:0]        mem_ramSel,
    input  logic [2:0]        mem_loadop,
    input  logic [4:0]        mem_regDest,
    output logic              ram_req,
    output logic              ram_we,
    output logic [29:0]       ram_addr,
    output logic [3:0]        ram_sel,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic              stall_req,
    output logic              wb_regWriteEnable,
    output logic [4:0]        wb_regDest,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    mem_state_e        state_reg;
    logic [CNT_W-1:0]  counter_reg;

    logic              req_reg;
    logic              we_reg;
    logic [29:0]       addr_reg;
    logic [3:0]        sel_reg;
    logic [DATA_W-1:0] wdata_reg;

    // Access context captured at the request edge so the ack/abort handling
    // does not depend on the upstream register once stall_req drops.
    logic              pend_load_reg;
    logic              pend_wen_reg;
    logic [2:0]        pend_loadop_reg;
    logic [1:0]        pend_low_reg;
    logic [4:0]        pend_dest_reg;

    logic              wb_wen_reg;
    logic [4:0]        wb_dest_reg;
    logic [DATA_W-1:0] wb_data_reg;
    logic              err_reg;

    logic              is_load;
    logic              is_store;
    logic              is_access;
    logic              misaligned;
    logic              timeout_hit;
    logic [DATA_W-1:0] ext_data;

    assign is_load   = (mem_memop[1:0] == MEMOP_LOAD);
    assign is_store  = (mem_memop[1:0] == MEMOP_STORE);
    assign is_access = is_load || is_store;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = is_access &&
                        is_misaligned(is_load, mem_loadop, mem_ramSel, mem_ramLowAddr);
`else
    assign misaligned = 1'b0;
`endif

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            assign timeout_hit = (counter_reg == CNT_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // Stall is released in the cycle the access finishes (ack or abort) so
    // the upstream register advances on the same edge we leave WAIT.
    always_comb begin
        stall_req = 1'b0;
        if (state_reg == ST_IDLE)
            stall_req = is_access && !misaligned;
        else
            stall_req = !(ram_ack || timeout_hit);
    end

    load_extender #(.DATA_W(DATA_W)) u_load_extender (
        .rdata    (ram_rdata),
        .low_addr (pend_low_reg),
        .loadop   (pend_loadop_reg),
        .data     (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            counter_reg     <= '0;
            req_reg         <= 1'b0;
            we_reg          <= 1'b0;
            addr_reg        <= '0;
            sel_reg         <= '0;
            wdata_reg       <= '0;
            pend_load_reg   <= 1'b0;
            pend_wen_reg    <= 1'b0;
            pend_loadop_reg <= LOADOP_NOP;
            pend_low_reg    <= '0;
            pend_dest_reg   <= '0;
            wb_wen_reg      <= 1'b0;
            wb_dest_reg     <= '0;
            wb_data_reg     <= '0;
            err_reg         <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (is_access) begin
                        wb_wen_reg <= 1'b0;
                        if (misaligned) begin
                            err_reg <= 1'b1;
                        end else begin
                            state_reg       <= ST_WAIT;
                            counter_reg     <= '0;
                            req_reg         <= 1'b1;
                            we_reg          <= is_store;
                            addr_reg        <= mem_ramAddr;
                            sel_reg         <= mem_ramSel;
                            wdata_reg       <= mem_storeData;
                            pend_load_reg   <= is_load;
                            pend_wen_reg    <= mem_memop[REGENABLE];
                            pend_loadop_reg <= mem_loadop;
                            pend_low_reg    <= mem_ramLowAddr;
                            pend_dest_reg   <= mem_regDest;
                        end
                    end else begin
                        wb_wen_reg  <= mem_memop[REGENABLE];
                        wb_dest_reg <= mem_regDest;
                        wb_data_reg <= mem_exresult;
                    end
                end
                ST_WAIT: begin
                    if (ram_ack) begin
                        state_reg   <= ST_IDLE;
                        counter_reg <= '0;
                        req_reg     <= 1'b0;
                        if (pend_load_reg) begin
                            wb_wen_reg  <= pend_wen_reg;
                            wb_dest_reg <= pend_dest_reg;
                            wb_data_reg <= ext_data;
                        end else begin
                            wb_wen_reg <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        state_reg   <= ST_IDLE;
                        counter_reg <= '0;
                        req_reg     <= 1'b0;
                        err_reg     <= 1'b1;
                        wb_wen_reg  <= 1'b0;
                    end else begin
                        counter_reg <= counter_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ram_req           = req_reg;
    assign ram_we            = we_reg;
    assign ram_addr          = addr_reg;
    assign ram_sel           = sel_reg;
    assign ram_wdata         = wdata_reg;
    assign wb_regWriteEnable = wb_wen_reg;
    assign wb_regDest        = wb_dest_reg;
    assign wb_data           = wb_data_reg;
    assign mem_err           = err_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
// Directed and randomized checks of mem_access_stage (TIMEOUT_CYCLES = 4).
// Expected write-back values come from a transaction-level model: the ALU
// result for plain ops, and byte/halfword selection by shifting plus
// sign/zero extension for loads.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  mem_memop;
    logic [31:0] mem_exresult;
    logic [31:0] mem_storeData;
    logic [29:0] mem_ramAddr;
    logic [1:0]  mem_ramLowAddr;
    logic [3:0]  mem_ramSel;
    logic [2:0]  mem_loadop;
    logic [4:0]  mem_regDest;
    logic        ram_req;
    logic        ram_we;
    logic [29:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;
    logic        stall_req;
    logic        wb_regWriteEnable;
    logic [4:0]  wb_regDest;
    logic [31:0] wb_data;
    logic        mem_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the MEM/WB register contents that persist across ops
    logic [31:0] exp_data;
    logic [4:0]  exp_dest;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(TMO), .DATA_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mem_memop         (mem_memop),
        .mem_exresult      (mem_exresult),
        .mem_storeData     (mem_storeData),
        .mem_ramAddr       (mem_ramAddr),
        .mem_ramLowAddr    (mem_ramLowAddr),
        .mem_ramSel        (mem_ramSel),
        .mem_loadop        (mem_loadop),
        .mem_regDest       (mem_regDest),
        .ram_req           (ram_req),
        .ram_we            (ram_we),
        .ram_addr          (ram_addr),
        .ram_sel           (ram_sel),
        .ram_wdata         (ram_wdata),
        .ram_rdata         (ram_rdata),
        .ram_ack           (ram_ack),
        .stall_req         (stall_req),
        .wb_regWriteEnable (wb_regWriteEnable),
        .wb_regDest        (wb_regDest),
        .wb_data           (wb_data),
        .mem_err           (mem_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference load result: shift the addressed lane down, then extend.
    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] low,
                                             input logic [2:0] lop);
        logic [31:0] b_sh;
        logic [31:0] h_sh;
        byte         b;
        shortint     h;
        b_sh = rd >> (8 * int'(low));
        h_sh = rd >> (16 * int'(low[1]));
        b = byte'(b_sh);
        h = shortint'(h_sh);
        case (lop)
            3'd1:    return 32'(int'(b));
            3'd2:    return b_sh & 32'h0000_00FF;
            3'd3:    return 32'(int'(h));
            3'd4:    return h_sh & 32'h0000_FFFF;
            3'd5:    return rd;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req"},   32'(ram_req), 32'h0);
        check({tag, "_we"},    32'(ram_we), 32'h0);
        check({tag, "_addr"},  32'(ram_addr), 32'h0);
        check({tag, "_sel"},   32'(ram_sel), 32'h0);
        check({tag, "_wdata"}, ram_wdata, 32'h0);
        check({tag, "_wen"},   32'(wb_regWriteEnable), 32'h0);
        check({tag, "_dest"},  32'(wb_regDest), 32'h0);
        check({tag, "_data"},  wb_data, 32'h0);
        check({tag, "_err"},   32'(mem_err), 32'h0);
    endtask

    // Plain ALU op (memop kind none or reserved); optional stray ack in IDLE.
    // Called at posedge+1, returns at posedge+1.
    task automatic do_alu(input string tag, input logic wen, input logic rsvd,
                          input logic [4:0] dest, input logic [31:0] res, input logic stray_ack);
        mem_memop    = {wen, rsvd ? 2'b11 : 2'b00};
        mem_exresult = res;
        mem_regDest  = dest;
        mem_loadop   = 3'($urandom_range(0, 5));
        ram_ack      = stray_ack;
        ram_rdata    = $urandom;
        @(negedge clk);
        check({tag, "_stall"}, 32'(stall_req), 32'h0);
        @(posedge clk);
        #1;
        ram_ack  = 1'b0;
        exp_data = res;
        exp_dest = dest;
        check({tag, "_wen"},  32'(wb_regWriteEnable), 32'(wen));
        check({tag, "_dest"}, 32'(wb_regDest), 32'(exp_dest));
        check({tag, "_data"}, wb_data, exp_data);
        check({tag, "_err"},  32'(mem_err), 32'h0);
        check({tag, "_req"},  32'(ram_req), 32'h0);
    endtask

    // Load or store with 'waits' WAIT cycles before the ack cycle (< TMO).
    task automatic do_mem(input string tag, input logic st, input logic wen,
                          input logic [2:0] lop, input logic [1:0] low,
                          input logic [29:0] addr, input logic [3:0] sel,
                          input logic [31:0] wd, input logic [4:0] dest,
                          input logic [31:0] rd, input int waits);
        mem_memop      = {wen, st ? 2'b10 : 2'b01};
        mem_exresult   = $urandom;
        mem_storeData  = wd;
        mem_ramAddr    = addr;
        mem_ramLowAddr = low;
        mem_ramSel     = sel;
        mem_loadop     = lop;
        mem_regDest    = dest;
        ram_ack        = 1'b0;
        @(negedge clk);
        check({tag, "_stall_idle"}, 32'(stall_req), 32'h1);
        @(posedge clk);
        #1;
        check({tag, "_wen_bubble"}, 32'(wb_regWriteEnable), 32'h0);
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin
                ram_ack   = 1'b1;
                ram_rdata = rd;
            end else begin
                ram_rdata = $urandom;
            end
            @(negedge clk);
            check({tag, "_req"},   32'(ram_req), 32'h1);
            check({tag, "_we"},    32'(ram_we), 32'(st));
            check({tag, "_addr"},  32'(ram_addr), 32'(addr));
            check({tag, "_sel"},   32'(ram_sel), 32'(sel));
            check({tag, "_wdata"}, ram_wdata, wd);
            check({tag, "_stall"}, 32'(stall_req), (i == waits) ? 32'h0 : 32'h1);
            @(posedge clk);
            #1;
        end
        ram_ack = 1'b0;
        if (!st) begin
            exp_data = ref_load(rd, low, lop);
            exp_dest = dest;
        end
        check({tag, "_req_done"}, 32'(ram_req), 32'h0);
        check({tag, "_wb_wen"},   32'(wb_regWriteEnable), st ? 32'h0 : 32'(wen));
        check({tag, "_wb_dest"},  32'(wb_regDest), 32'(exp_dest));
        check({tag, "_wb_data"},  wb_data, exp_data);
        check({tag, "_err"},      32'(mem_err), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  lop;
        logic [1:0]  low;
        logic [3:0]  sel;
        int          kind;

        rst_n          = 1'b0;
        mem_memop      = '0;
        mem_exresult   = '0;
        mem_storeData  = '0;
        mem_ramAddr    = '0;
        mem_ramLowAddr = '0;
        mem_ramSel     = '0;
        mem_loadop     = '0;
        mem_regDest    = '0;
        ram_rdata      = '0;
        ram_ack        = 1'b0;
        exp_data       = '0;
        exp_dest       = '0;

        #12;
        check_outputs_zero("reset");
        check("reset_stall", 32'(stall_req), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed steps
        do_alu("alu_1234", 1'b1, 1'b0, 5'd7, 32'h0000_1234, 1'b0);
        do_mem("lb_lane2", 1'b0, 1'b1, 3'd1, 2'd2, 30'h0000_0100, 4'b0100,
               32'h0, 5'd3, 32'h0080_FF00, 2);
        check("lb_lane2_value", wb_data, 32'hFFFF_FF80);
        do_mem("lhu_hi", 1'b0, 1'b1, 3'd4, 2'd2, 30'h0000_0200, 4'b1100,
               32'h0, 5'd4, 32'h8001_0000, 0);
        check("lhu_hi_value", wb_data, 32'h0000_8001);
        do_mem("lh_hi", 1'b0, 1'b1, 3'd3, 2'd2, 30'h0000_0200, 4'b1100,
               32'h0, 5'd5, 32'h8001_0000, 1);
        check("lh_hi_value", wb_data, 32'hFFFF_8001);
        do_mem("store_half", 1'b1, 1'b0, 3'd0, 2'd0, 30'h0ABC_DEF0, 4'b0011,
               32'hAABB_CCDD, 5'd9, 32'h0, 3);
        do_alu("alu_rsvd", 1'b1, 1'b1, 5'd12, 32'hCAFE_0001, 1'b1);
        do_alu("alu_ack_idle", 1'b0, 1'b0, 5'd13, 32'h0BAD_F00D, 1'b1);

        // Timeout: load with no ack aborts after TMO WAIT cycles
        mem_memop      = 3'b101;
        mem_loadop     = 3'd5;
        mem_ramLowAddr = 2'd0;
        mem_ramAddr    = 30'h0000_0777;
        mem_regDest    = 5'd21;
        ram_ack        = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            check("tmo_req", 32'(ram_req), 32'h1);
            check("tmo_stall", 32'(stall_req), (i == TMO - 1) ? 32'h0 : 32'h1);
            check("tmo_err_early", 32'(mem_err), 32'h0);
            @(posedge clk);
            #1;
        end
        check("tmo_err_pulse", 32'(mem_err), 32'h1);
        check("tmo_req_drop", 32'(ram_req), 32'h0);
        check("tmo_no_wb", 32'(wb_regWriteEnable), 32'h0);
        mem_memop = 3'b000;
        @(posedge clk);
        #1;
        check("tmo_err_once", 32'(mem_err), 32'h0);
        exp_data = mem_exresult;
        exp_dest = mem_regDest;

        // Reset in the middle of WAIT
        mem_memop   = 3'b101;
        mem_loadop  = 3'd5;
        mem_regDest = 5'd30;
        @(posedge clk);
        #1;
        check("rstwait_req", 32'(ram_req), 32'h1);
        #2;
        rst_n     = 1'b0;
        mem_memop = 3'b000;
        #1;
        check_outputs_zero("rstwait");
        check("rstwait_stall", 32'(stall_req), 32'h0);
        exp_data = '0;
        exp_dest = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_alu("alu_after_rst", 1'b1, 1'b0, 5'd1, 32'h5555_AAAA, 1'b0);

        // Randomized aligned traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                do_alu("rnd_alu", 1'($urandom), 1'($urandom), 5'($urandom), $urandom,
                       1'($urandom));
            end else if (kind == 1) begin
                lop = 3'($urandom_range(0, 5));
                low = 2'($urandom);
                if (lop == 3'd3 || lop == 3'd4) low[0] = 1'b0;
                if (lop == 3'd5) low = 2'd0;
                do_mem("rnd_load", 1'b0, 1'($urandom), lop, low, 30'($urandom), 4'b1111,
                       $urandom, 5'($urandom), $urandom, int'($urandom_range(0, TMO - 1)));
            end else begin
                case ($urandom_range(0, 2))
                    0:       begin low = 2'($urandom); sel = 4'(1 << low); end
                    1:       begin low = {1'($urandom), 1'b0}; sel = low[1] ? 4'b1100 : 4'b0011; end
                    default: begin low = 2'd0; sel = 4'b1111; end
                endcase
                do_mem("rnd_store", 1'b1, 1'($urandom), 3'd0, low, 30'($urandom), sel,
                       $urandom, 5'($urandom), $urandom, int'($urandom_range(0, TMO - 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage, directly downstream of the EX/MEM pipeline register.
- Consumes the registered memop, ALU result, RAM address/select, load op and destination register.
- Drives a request/acknowledge data-RAM port and holds the pipeline (stall_req) until the access completes.
- Extracts and extends load data, then registers the write-back bundle into the MEM/WB boundary.

Parameters:
- TIMEOUT_CYCLES, 16: max wait cycles for ram_ack before the access is aborted; 0 disables the timeout.
- DATA_W, 32: word width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- mem_memop  in  3  bit2 = reg write enable; [1:0] 00 = none, 01 = load, 10 = store, 11 = reserved (treated as none)
- mem_exresult  in  32  ALU result (write-back value for non-load ops)
- mem_storeData  in  32  store data, already lane-replicated
- mem_ramAddr  in  30  word address (address bits [31:2])
- mem_ramLowAddr  in  2  byte offset
- mem_ramSel  in  4  byte enables for the store
- mem_loadop  in  3  NOP=0, LB=1, LBU=2, LH=3, LHU=4, LW=5
- mem_regDest  in  5  destination register
- ram_req  out  1  access request
- ram_we  out  1  1 = write
- ram_addr  out  30  word address
- ram_sel  out  4  byte enables
- ram_wdata  out  32  write data
- ram_rdata  in  32  read data, valid when ram_ack = 1
- ram_ack  in  1  one-cycle completion pulse
- stall_req  out  1  freeze EX/MEM and all earlier stages
- wb_regWriteEnable  out  1  registered write-back enable
- wb_regDest  out  5  registered destination register
- wb_data  out  32  registered write-back data
- mem_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst_n = 0, asynchronous): state = IDLE, counter = 0.
  - ram_req, ram_we, ram_addr, ram_sel, ram_wdata = 0.
  - wb_regWriteEnable = 0, wb_regDest = 0, wb_data = 0, mem_err = 0.
  - An access in flight is dropped without a write-back.
- States: IDLE, WAIT.
- IDLE, memop none/reserved:
  - Next edge: wb_regWriteEnable <= memop[2], wb_regDest <= regDest, wb_data <= exresult.
  - Latency 1; stall_req = 0.
- IDLE, memop load/store:
  - stall_req = 1 combinationally.
  - Next edge: go to WAIT, register ram_req = 1, we, addr, sel and wdata.
  - wb_regWriteEnable <= 0, inserting a bubble.
- WAIT:
  - ram_req and all ram_* outputs are held stable; the counter increments each cycle.
  - stall_req = 1 unless ram_ack = 1.
- WAIT with ram_ack = 1:
  - stall_req = 0 in that same cycle.
  - Next edge: ram_req <= 0, state <= IDLE, counter <= 0.
  - Load: wb_data <= extended rdata, wb_regWriteEnable <= memop[2].
  - Store: wb_regWriteEnable <= 0.
  - The following memop is therefore sampled in IDLE on the next cycle.
  - Minimum load/store latency: 2 cycles (request edge, then ack edge).
- Timeout: counter == TIMEOUT_CYCLES - 1 in WAIT without ack.
  - Abort to IDLE, ram_req <= 0, mem_err <= 1 for one cycle, no write-back.
  - stall_req drops in that cycle.
- A ram_ack in IDLE is ignored.
- Load extraction, byte lanes little-endian (lane k = rdata[8k+7:8k]):
  - LB / LBU: lane = lowAddr, sign- or zero-extended.
  - LH / LHU: half = lowAddr[1], sign- or zero-extended.
  - LW: rdata unchanged.
  - NOP on a load memop: 0.
- While stalled, the upstream register must hold its inputs; this block reads its inputs only in IDLE.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: a load/store is misaligned when LH/LHU/half-store has lowAddr[0] = 1, or LW/word-store has lowAddr != 0.
  - A misaligned access issues no RAM request and stays in IDLE.
  - It pulses mem_err for 1 cycle and produces no write-back.
- Undefined: no check; misaligned accesses proceed with the offset bits ignored as described above.

Decomposition:
- Shared package/header holds the memop codes, the REGENABLE bit index, loadop codes, and the IDLE/WAIT encodings.
- Sub-module load_extender: combinational (rdata, lowAddr, loadop) -> 32-bit data, reused by any future cache path.

Test Plan:
- ALU op, memop = 3'b100, exresult = 0x1234: next cycle wb_regWriteEnable = 1, wb_data = 0x1234, stall_req never 1.
- LB at lowAddr = 2, rdata = 0x0080FF00, ack after 3 WAIT cycles: stall_req high for 3 cycles, low on the ack cycle; wb_data = 0xFFFFFF80.
- LHU at lowAddr = 2, rdata = 0x8001_0000: wb_data = 0x00008001. Same access as LH: wb_data = 0xFFFF8001.
- Store with sel = 4'b0011, wdata = 0xAABBCCDD: ram_we = 1 and ram_* stay stable until ack; wb_regWriteEnable = 0.
- No ack with TIMEOUT_CYCLES = 4: after 4 WAIT cycles, mem_err pulses once, ram_req drops, no write-back.
- rst_n low in the middle of WAIT: all outputs go to 0 immediately; after release the next ALU op completes in 1 cycle.
